idecode_32: RTL and testbench



---
 rtl/idecode_32_pkg.sv | 52 +++++
 rtl/idecode_32_regfile32.sv | 36 +++
 rtl/idecode_32.sv | 90 +++++++++
 tb/tb_idecode_32.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/idecode_32_pkg.sv
// Shared definitions for the Minisys-1A instruction-decode stage:
// opcode constants, special register numbers and instruction field helpers.
package idecode_32_pkg;

    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] REGIMM  = 6'h01;
    localparam logic [5:0] J       = 6'h02;
    localparam logic [5:0] JAL     = 6'h03;
    localparam logic [5:0] ANDI    = 6'h0C;
    localparam logic [5:0] ORI     = 6'h0D;
    localparam logic [5:0] XORI    = 6'h0E;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } instr_fields_t;

    // Which source feeds the write port; order mirrors link priority.
    typedef enum logic [1:0] {
        WB_NORMAL = 2'd0,
        WB_JAL    = 2'd1,
        WB_JALR   = 2'd2,
        WB_BLINK  = 2'd3
    } wb_sel_t;

    function automatic instr_fields_t split_fields(input logic [31:0] instr);
        instr_fields_t f;
        f.op  = instr[31:26];
        f.rs  = instr[25:21];
        f.rt  = instr[20:16];
        f.rd  = instr[15:11];
        f.imm = instr[15:0];
        return f;
    endfunction

    // Logical immediates are unsigned; everything else is sign-extended.
    function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic zero_ext;
        zero_ext = (op == ANDI) || (op == ORI) || (op == XORI);
        if (zero_ext)
            return {16'h0000, imm};
        else
            return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/idecode_32_regfile32.sv
// 32x32 general register file: three asynchronous read ports, one write port
// updated on the falling clock edge, synchronous clear, $0 hardwired to zero.
module regfile32
    import idecode_32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    input  logic [4:0]  raddr_c,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] rdata_c
);

    logic [31:0] regs [32];

    // Falling-edge update lets the second half of a cycle see its own write.
    always_ff @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == REG_ZERO) ? 32'h0000_0000 : regs[raddr_a];
    assign rdata_b = (raddr_b == REG_ZERO) ? 32'h0000_0000 : regs[raddr_b];
    assign rdata_c = (raddr_c == REG_ZERO) ? 32'h0000_0000 : regs[raddr_c];

endmodule

// File: rtl/idecode_32.sv
// ID stage of the Minisys-1A pipeline: field split, immediate extension, jump
// target, write-back address/data resolution (including links) and register file.
module idecode_32
    import idecode_32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ID_opcplus4,
    input  logic [31:0] Instruction,
    input  logic [31:0] Wdata,
    input  logic [4:0]  Waddr,
    input  logic        Jal,
    input  logic        Jalr,
    input  logic        Bgezal,
    input  logic        Bltzal,
    input  logic        Negative,
    input  logic        RegWrite,
    output logic [31:0] ID_Jpc,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [4:0]  write_address_1,
    output logic [4:0]  write_address_0,
    output logic [31:0] write_data,
    output logic [4:0]  write_register_address,
    output logic [31:0] sign_extend,
    output logic [4:0]  rs,
    output logic [31:0] rd_data
);

    instr_fields_t fields;
    wb_sel_t       wb_sel;
    logic          branch_link;
    logic          link;
    logic          write_enable;

    assign fields = split_fields(Instruction);

    assign rs              = fields.rs;
    assign write_address_0 = fields.rt;
    assign write_address_1 = fields.rd;
    assign sign_extend     = extend_imm(fields.op, fields.imm);
    assign ID_Jpc          = {ID_opcplus4[31:26], Instruction[25:0]};

    assign branch_link  = (Bgezal & ~Negative) | (Bltzal & Negative);
    assign link         = Jal | Jalr | branch_link;
    assign write_enable = RegWrite | link;

    // Priority Jal > Jalr > qualified branch-and-link > ordinary write-back.
    always_comb begin
        wb_sel                 = WB_NORMAL;
        write_register_address = Waddr;
        write_data             = Wdata;
        if (Jal)
            wb_sel = WB_JAL;
        else if (Jalr)
            wb_sel = WB_JALR;
        else if (branch_link)
            wb_sel = WB_BLINK;

        case (wb_sel)
            WB_JAL, WB_BLINK: begin
                write_register_address = REG_RA;
                write_data             = ID_opcplus4;
            end
            WB_JALR: begin
                write_register_address = Waddr;
                write_data             = ID_opcplus4;
            end
            default: begin
                write_register_address = Waddr;
                write_data             = Wdata;
            end
        endcase
    end

    regfile32 u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (write_enable),
        .waddr   (write_register_address),
        .wdata   (write_data),
        .raddr_a (fields.rs),
        .raddr_b (fields.rt),
        .raddr_c (fields.rd),
        .rdata_a (read_data_1),
        .rdata_b (read_data_2),
        .rdata_c (rd_data)
    );

endmodule

// File: tb/tb_idecode_32.sv
// Directed bench for idecode_32: hand-computed vectors checked with immediate
// assertions, sampled 1 time unit after the falling (register-file) edge.
module tb_idecode_32;

    logic        clock;
    logic        reset;
    logic [31:0] ID_opcplus4;
    logic [31:0] Instruction;
    logic [31:0] Wdata;
    logic [4:0]  Waddr;
    logic        Jal, Jalr, Bgezal, Bltzal, Negative, RegWrite;
    logic [31:0] ID_Jpc, read_data_1, read_data_2, write_data, sign_extend, rd_data;
    logic [4:0]  write_address_1, write_address_0, write_register_address, rs;

    int checks = 0;
    int errors = 0;

    idecode_32 dut (
        .clock                  (clock),
        .reset                  (reset),
        .ID_opcplus4            (ID_opcplus4),
        .Instruction            (Instruction),
        .Wdata                  (Wdata),
        .Waddr                  (Waddr),
        .Jal                    (Jal),
        .Jalr                   (Jalr),
        .Bgezal                 (Bgezal),
        .Bltzal                 (Bltzal),
        .Negative               (Negative),
        .RegWrite               (RegWrite),
        .ID_Jpc                 (ID_Jpc),
        .read_data_1            (read_data_1),
        .read_data_2            (read_data_2),
        .write_address_1        (write_address_1),
        .write_address_0        (write_address_0),
        .write_data             (write_data),
        .write_register_address (write_register_address),
        .sign_extend            (sign_extend),
        .rs                     (rs),
        .rd_data                (rd_data)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_wb();
        Jal = 0; Jalr = 0; Bgezal = 0; Bltzal = 0; Negative = 0; RegWrite = 0;
        Waddr = 5'd0; Wdata = 32'h0;
    endtask

    initial begin
        reset = 1; ID_opcplus4 = 32'h0; Instruction = 32'h0;
        clear_wb();
        tick();
        tick();
        reset = 0;

        // Reset state and field decode of lui $8,0xFFFF
        Instruction = 32'h3C08FFFF;
        #1;
        check("rs_after_reset", {27'd0, rs}, 32'd0);
        check("rt_field", {27'd0, write_address_0}, 32'd8);
        check("lui_sign_ext", sign_extend, 32'hFFFFFFFF);
        check("rd1_after_reset", read_data_1, 32'h0);
        check("rd2_after_reset", read_data_2, 32'h0);
        check("rd_data_after_reset", rd_data, 32'h0);

        // Ordinary write of $8, then add $10,$8,$9 reads it back
        RegWrite = 1; Waddr = 5'd8; Wdata = 32'hFFFF0000;
        Instruction = 32'h01095020;
        #1;
        check("wb_addr_normal", {27'd0, write_register_address}, 32'd8);
        check("wb_data_normal", write_data, 32'hFFFF0000);
        tick();
        clear_wb();
        check("rd1_reg8", read_data_1, 32'hFFFF0000);
        check("rd_field", {27'd0, write_address_1}, 32'd10);
        check("rd2_reg9", read_data_2, 32'h0);

        // jal links PC+1 into $31
        Jal = 1; ID_opcplus4 = 32'h4; Wdata = 32'h0;
        #1;
        check("jal_addr", {27'd0, write_register_address}, 32'd31);
        check("jal_data", write_data, 32'h4);
        tick();
        clear_wb();
        Instruction = 32'h03E00000;
        #1;
        check("reg31_after_jal", read_data_1, 32'h4);

        // Jal outranks Jalr
        Jal = 1; Jalr = 1; Waddr = 5'd5;
        #1;
        check("jal_over_jalr", {27'd0, write_register_address}, 32'd31);
        clear_wb();

        // bgezal taken
        Bgezal = 1; Negative = 0; ID_opcplus4 = 32'h6;
        tick();
        clear_wb();
        check("reg31_after_bgezal", read_data_1, 32'h6);

        // bltzal not taken: ordinary write of $16 instead
        Bltzal = 1; Negative = 0; RegWrite = 1; Waddr = 5'h10; Wdata = 32'hFFFFFFF0;
        #1;
        check("bltzal_nolink_addr", {27'd0, write_register_address}, 32'h10);
        check("bltzal_nolink_data", write_data, 32'hFFFFFFF0);
        tick();
        clear_wb();
        Instruction = 32'h021F0000;
        #1;
        check("reg16", read_data_1, 32'hFFFFFFF0);
        check("reg31_kept", read_data_2, 32'h6);

        // bltzal taken (combinational only) and bgezal with Negative=1 not taken
        Bltzal = 1; Negative = 1; ID_opcplus4 = 32'h99; Waddr = 5'd3; Wdata = 32'h77;
        #1;
        check("bltzal_link_addr", {27'd0, write_register_address}, 32'd31);
        check("bltzal_link_data", write_data, 32'h99);
        Bltzal = 0; Bgezal = 1;
        #1;
        check("bgezal_neg_addr", {27'd0, write_register_address}, 32'd3);
        check("bgezal_neg_data", write_data, 32'h77);
        clear_wb();

        // jalr links into Waddr
        Jalr = 1; Waddr = 5'h1E; ID_opcplus4 = 32'hA; Wdata = 32'h55;
        #1;
        check("jalr_addr", {27'd0, write_register_address}, 32'h1E);
        check("jalr_data", write_data, 32'hA);
        tick();
        clear_wb();
        Instruction = 32'h0000F000;
        #1;
        check("reg30_via_rd_data", rd_data, 32'hA);

        // Writes to $0 are discarded
        RegWrite = 1; Waddr = 5'd0; Wdata = 32'h30;
        tick();
        clear_wb();
        Instruction = 32'h00000000;
        #1;
        check("reg0_rd1", read_data_1, 32'h0);
        check("reg0_rd_data", rd_data, 32'h0);

        // Jump target and extension cases
        Instruction = 32'h0C000005; ID_opcplus4 = 32'h1;
        #1;
        check("jpc_jal", ID_Jpc, 32'h00000005);
        Instruction = 32'h0BFFFFFF; ID_opcplus4 = 32'hFC000000;
        #1;
        check("jpc_upper_bits", ID_Jpc, 32'hFFFFFFFF);
        Instruction = 32'h3508FFFF;
        #1;
        check("ori_zero_ext", sign_extend, 32'h0000FFFF);
        Instruction = 32'h3108FFFF;
        #1;
        check("andi_zero_ext", sign_extend, 32'h0000FFFF);
        Instruction = 32'h3908FFFF;
        #1;
        check("xori_zero_ext", sign_extend, 32'h0000FFFF);
        Instruction = 32'h2108FFFF;
        #1;
        check("addi_sign_ext", sign_extend, 32'hFFFFFFFF);
        Instruction = 32'h21087FFF;
        #1;
        check("addi_pos_ext", sign_extend, 32'h00007FFF);

        // Reset mid-sequence clears the file and drops the pending write
        RegWrite = 1; Waddr = 5'h10; Wdata = 32'h1234;
        reset = 1;
        tick();
        reset = 0;
        clear_wb();
        Instruction = 32'h021F0000;
        #1;
        check("reg16_after_reset", read_data_1, 32'h0);
        check("reg31_after_reset", read_data_2, 32'h0);
        Instruction = 32'h01000000;
        #1;
        check("reg8_after_reset", read_data_1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
